// File: rtl/memory_loader.sv
// Byte-serial 4x4 matrix loader with a single sequential MAC computing C = A x W into Feature_Memory[16:31].
// Define MEMORY_LOADER_SAT_EN to saturate result bytes at 255 instead of truncating to the low 8 bits.
module memory_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_A,
    input  logic [7:0] port_W,
    input  logic       write_enable_A,
    input  logic       write_enable_W,
    input  logic       startSignal,
    output logic [7:0] port_O,
    output logic       done
);

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t      state;
    logic [7:0]  Feature_Memory [0:31];
    logic [7:0]  Weight_Memory  [0:15];
    logic [3:0]  ptr_A;
    logic [3:0]  ptr_W;
    logic [1:0]  i;
    logic [1:0]  j;
    logic [1:0]  k;
    logic [17:0] acc;
    logic        start_q;

    logic        start_edge;
    logic [15:0] product;
    logic [17:0] sum;
    logic [7:0]  result;

    always_comb begin
        start_edge = startSignal & ~start_q;
        product    = Feature_Memory[{1'b0, i, k}] * Weight_Memory[{k, j}];
        sum        = acc + {2'b00, product};
`ifdef MEMORY_LOADER_SAT_EN
        result     = (sum > 18'd255) ? 8'hFF : sum[7:0];
`else
        result     = sum[7:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr_A   <= '0;
            ptr_W   <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            start_q <= 1'b0;
            port_O  <= '0;
            done    <= 1'b0;
            for (int unsigned n = 0; n < 32; n++) Feature_Memory[n] <= '0;
            for (int unsigned n = 0; n < 16; n++) Weight_Memory[n]  <= '0;
        end else begin
            start_q <= startSignal;
            case (state)
                IDLE: begin
                    if (write_enable_A) begin
                        Feature_Memory[{1'b0, ptr_A}] <= port_A;
                        ptr_A <= ptr_A + 4'd1;
                    end
                    if (write_enable_W) begin
                        Weight_Memory[ptr_W] <= port_W;
                        ptr_W <= ptr_W + 4'd1;
                    end
                    if (start_edge) begin
                        state <= COMPUTE;
                        done  <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                COMPUTE: begin
                    // k innermost; the 2-bit counters wrap naturally at 3
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        Feature_Memory[{1'b1, i, j}] <= result;
                        port_O <= result;
                        acc    <= '0;
                        j      <= j + 2'd1;
                        if (j == 2'd3) begin
                            i <= i + 2'd1;
                            if (i == 2'd3) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        acc <= sum;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Directed self-checking bench for memory_loader: load, multiply timing, overflow, pointer wrap,
// mid-compute reset and ignored inputs during COMPUTE.
module tb_memory_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_A;
    logic [7:0] port_W;
    logic       write_enable_A;
    logic       write_enable_W;
    logic       startSignal;
    logic [7:0] port_O;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] w_vec [16];
    logic [7:0] a_vec [16];
    logic [7:0] c_exp [16];

`ifdef MEMORY_LOADER_SAT_EN
    localparam logic [7:0] OVF = 8'd255;
`else
    localparam logic [7:0] OVF = 8'd4;
`endif

    memory_loader dut (
        .clk            (clk),
        .rst            (rst),
        .port_A         (port_A),
        .port_W         (port_W),
        .write_enable_A (write_enable_A),
        .write_enable_W (write_enable_W),
        .startSignal    (startSignal),
        .port_O         (port_O),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic ea, input logic [7:0] a, input logic ew, input logic [7:0] w);
        write_enable_A = ea;
        port_A         = a;
        write_enable_W = ew;
        port_W         = w;
        step();
        write_enable_A = 1'b0;
        write_enable_W = 1'b0;
    endtask

    task automatic check_loaded();
        for (int e = 0; e < 16; e++) begin
            check($sformatf("A[%0d]", e), {24'd0, dut.Feature_Memory[e]}, {24'd0, a_vec[e]});
            check($sformatf("W[%0d]", e), {24'd0, dut.Weight_Memory[e]}, {24'd0, w_vec[e]});
        end
    endtask

    // Produces a fresh start edge, checks first-result latency, done timing and all results.
    // With inject set, writes and a second start edge are driven mid-run.
    task automatic run_mul(input string tag, input logic inject);
        startSignal = 1'b0;
        step();
        startSignal = 1'b1;
        step();
        for (int cyc = 1; cyc <= 63; cyc++) begin
            step();
            if (cyc == 4) check({tag, "_first_port_O"}, {24'd0, port_O}, {24'd0, c_exp[0]});
            if (inject) begin
                if (cyc == 10) begin
                    write_enable_A = 1'b1; port_A = 8'd7;
                    write_enable_W = 1'b1; port_W = 8'd9;
                end
                if (cyc == 20) startSignal = 1'b0;
                if (cyc == 21) startSignal = 1'b1;
                if (cyc == 22) begin
                    write_enable_A = 1'b0;
                    write_enable_W = 1'b0;
                end
            end
        end
        check({tag, "_done_at_63"}, {31'd0, done}, 32'd0);
        step();
        check({tag, "_done_at_64"}, {31'd0, done}, 32'd1);
        check({tag, "_last_port_O"}, {24'd0, port_O}, {24'd0, c_exp[15]});
        for (int e = 0; e < 16; e++)
            check($sformatf("%s_C[%0d]", tag, e), {24'd0, dut.Feature_Memory[16 + e]}, {24'd0, c_exp[e]});
    endtask

    initial begin
        w_vec = '{8'd4, 8'd0, 8'd2, 8'd1,
                  8'd4, 8'd3, 8'd2, 8'd0,
                  8'd4, 8'd3, 8'd0, 8'd1,
                  8'd4, 8'd3, 8'd2, 8'd1};
        for (int e = 0; e < 16; e++) a_vec[e] = 8'((e % 4) + 1);
        // Each C row = {1,2,3,4} x W = {40,27,14,8}
        for (int e = 0; e < 16; e++) begin
            case (e % 4)
                0: c_exp[e] = 8'd40;
                1: c_exp[e] = 8'd27;
                2: c_exp[e] = 8'd14;
                default: c_exp[e] = 8'd8;
            endcase
        end

        rst = 1'b0;
        port_A = '0; port_W = '0;
        write_enable_A = 1'b0; write_enable_W = 1'b0;
        startSignal = 1'b0;
        step();
        step();
        check("rst_port_O", {24'd0, port_O}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ptr_A", {28'd0, dut.ptr_A}, 32'd0);
        check("rst_F0", {24'd0, dut.Feature_Memory[0]}, 32'd0);
        #2 rst = 1'b1;
        step();

        // Load W then A separately
        for (int e = 0; e < 16; e++) wr(1'b0, 8'd0, 1'b1, w_vec[e]);
        for (int e = 0; e < 16; e++) wr(1'b1, a_vec[e], 1'b0, 8'd0);
        check_loaded();
        for (int e = 16; e < 32; e++)
            check($sformatf("upper[%0d]", e), {24'd0, dut.Feature_Memory[e]}, 32'd0);

        run_mul("mul", 1'b0);
        // start stays high: no retrigger
        for (int n = 0; n < 5; n++) step();
        check("held_done", {31'd0, done}, 32'd1);
        check("held_port_O", {24'd0, port_O}, 32'd8);

        // Pointer wrap: 17 writes from ptr_A=0
        for (int n = 0; n < 17; n++) wr(1'b1, 8'(10 + n), 1'b0, 8'd0);
        check("wrap_idx0", {24'd0, dut.Feature_Memory[0]}, 32'd26);
        check("wrap_idx1", {24'd0, dut.Feature_Memory[1]}, 32'd11);
        check("wrap_idx15", {24'd0, dut.Feature_Memory[15]}, 32'd25);
        check("wrap_ptr_A", {28'd0, dut.ptr_A}, 32'd1);

        // Overflow data, both ports writing together, with ignored inputs mid-run
        for (int e = 0; e < 16; e++) wr(1'b1, 8'd255, 1'b1, 8'd255);
        for (int e = 0; e < 16; e++) begin
            a_vec[e] = 8'd255;
            w_vec[e] = 8'd255;
            c_exp[e] = OVF;
        end
        run_mul("ovf", 1'b1);
        check_loaded();
        check("ign_ptr_A", {28'd0, dut.ptr_A}, 32'd1);
        check("ign_ptr_W", {28'd0, dut.ptr_W}, 32'd0);

        // Mid-compute reset
        startSignal = 1'b0;
        step();
        startSignal = 1'b1;
        step();
        for (int n = 0; n < 10; n++) step();
        check("pre_rst_port_O", {24'd0, port_O}, {24'd0, OVF});
        #2 rst = 1'b0;
        startSignal = 1'b0;
        #1;
        check("mid_rst_port_O", {24'd0, port_O}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_ptr_A", {28'd0, dut.ptr_A}, 32'd0);
        check("mid_rst_acc", {14'd0, dut.acc}, 32'd0);
        for (int e = 0; e < 32; e++)
            check($sformatf("mid_rst_F[%0d]", e), {24'd0, dut.Feature_Memory[e]}, 32'd0);
        for (int e = 0; e < 16; e++)
            check($sformatf("mid_rst_W[%0d]", e), {24'd0, dut.Weight_Memory[e]}, 32'd0);
        step();
        rst = 1'b1;
        step();

        w_vec = '{8'd4, 8'd0, 8'd2, 8'd1,
                  8'd4, 8'd3, 8'd2, 8'd0,
                  8'd4, 8'd3, 8'd0, 8'd1,
                  8'd4, 8'd3, 8'd2, 8'd1};
        for (int e = 0; e < 16; e++) begin
            a_vec[e] = 8'((e % 4) + 1);
            case (e % 4)
                0: c_exp[e] = 8'd40;
                1: c_exp[e] = 8'd27;
                2: c_exp[e] = 8'd14;
                default: c_exp[e] = 8'd8;
            endcase
        end
        for (int e = 0; e < 16; e++) wr(1'b1, a_vec[e], 1'b1, w_vec[e]);
        check_loaded();
        run_mul("rerun", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
